feature_pool_head: RTL

Downstream consumer of the accelerator's scaled feature stream (`out_sample`/`out_valid` of the top-level pipeline). The block does temporal global-average pooling over non-overlapping groups of POOL_LEN feature samples. For each group it emits one pooled value and a one-bit threshold class decision through a ready/valid output handshake. It is the first stage of the classification head and holds each result until the host interface accepts it.

---
 rtl/feature_pool_head.sv | 82 ++++++++
 1 files changed

// File: rtl/feature_pool_head.sv
// Temporal global-average pooling over POOL_LEN-sample groups, with a
// one-bit threshold class and a ready/valid result register.
module feature_pool_head #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned POOL_LEN   = 32,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int          THRESHOLD  = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic signed [DATA_WIDTH-1:0]       in_sample,
    input  logic                               in_valid,
    input  logic                               clear,
    output logic signed [DATA_WIDTH-1:0]       out_pool,
    output logic                               out_class,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               overrun,
    output logic [$clog2(POOL_LEN)-1:0]        group_cnt
);

    localparam int unsigned CNT_W = $clog2(POOL_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(POOL_LEN - 1);
    localparam logic signed [DATA_WIDTH-1:0] THRESH = DATA_WIDTH'(THRESHOLD);

    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [DATA_WIDTH-1:0] mean;
    logic                         accept;
    logic                         complete;
    logic                         slot_free;

    // Clear takes priority over a same-cycle sample.
    always_comb begin
        accept    = in_valid && !clear;
        complete  = accept && (group_cnt == LAST_IDX);
        slot_free = !out_valid || out_ready;
        sum       = acc + ACC_WIDTH'(in_sample);
        // Arithmetic shift floors toward -inf; the group mean always fits DATA_WIDTH.
        mean      = DATA_WIDTH'(sum >>> CNT_W);
    end

    // Accumulator, group counter and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            group_cnt <= '0;
            overrun   <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            group_cnt <= '0;
            overrun   <= 1'b0;
        end else if (accept) begin
            if (complete) begin
                acc       <= '0;
                group_cnt <= '0;
                if (!slot_free) begin
                    overrun <= 1'b1;
                end
            end else begin
                acc       <= sum;
                group_cnt <= group_cnt + CNT_W'(1);
            end
        end
    end

    // Result slot: load on completion when free, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pool  <= '0;
            out_class <= 1'b0;
            out_valid <= 1'b0;
        end else if (complete && slot_free) begin
            out_pool  <= mean;
            out_class <= (mean >= THRESH);
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
